// File: rtl/soup_pkg.sv
// soup_pkg: state encoding, soup width helpers and result layout shared by the soup scheduler.
package soup_pkg;
  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;
  function automatic int seed_w(input int init);
    return init * init;
  endfunction
  function automatic int res_w(input int init);
    return init * init + 32;
  endfunction
  localparam int INIT_DEF = 20;
  typedef struct packed {
    logic [31:0] step;
    logic [seed_w(INIT_DEF)-1:0] rng;
  } result_t;
endpackage

// File: rtl/soup_rr_arb.sv
// soup_rr_arb: round-robin one-hot arbiter; the search starts just after the last granted index.
module soup_rr_arb #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [3:0]   idx,
  output logic         valid
);
  logic [3:0] ptr;
  logic [N-1:0] rot;
  logic [4:0] sum;
  always_comb begin
    rot = N'({req, req} >> ptr);
    valid = 1'b0;
    idx = '0;
    sum = '0;
    grant = '0;
    for (int i = 0; i < N; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        sum = {1'b0, ptr} + 5'(i);
        idx = sum >= 5'(N) ? 4'(sum - 5'(N)) : sum[3:0];
      end
    end
    for (int k = 0; k < N; k++) grant[k] = valid && idx == 4'(k);
  end
  always_ff @(posedge clk) begin
    if (reset) ptr <= '0;
    else if (valid) ptr <= idx == 4'(N - 1) ? 4'd0 : idx + 4'd1;
  end
endmodule

// File: rtl/soup_sched.sv
// soup_sched: batch scheduler for NCORE life cores with best-result merge.
// Optional per-core watchdog is enabled by defining SCHED_WATCHDOG_EN.
module soup_sched
  import soup_pkg::*;
#(
  parameter int NCORE = 4,
  parameter int INIT = 20,
  parameter logic [31:0] WDOG = 32'd50_000_000,
  localparam int SEEDW = seed_w(INIT),
  localparam int RESW = res_w(INIT)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [31:0]           batch_count,
  output logic [NCORE-1:0]      core_run,
  input  logic [NCORE-1:0]      core_life,
  input  logic [NCORE*RESW-1:0] core_data,
  output logic                  busy,
  output logic                  done,
  output logic [31:0]           best_step,
  output logic [SEEDW-1:0]      best_rng,
  output logic [3:0]            best_core,
  output logic [31:0]           jobs_done,
  output logic [NCORE-1:0]      core_fault
);
  typedef struct packed {
    logic [31:0] step;
    logic [SEEDW-1:0] rng;
  } res_t;
  state_t state, nxt;
  logic [NCORE-1:0] act, pend, elig, run_oh, gnt, wd_hit;
  logic [31:0] issued, batch;
  res_t pdat [NCORE];
  res_t mres;
  logic go, issue, mvalid;
  logic [3:0] gidx;
  soup_rr_arb #(.N(NCORE)) u_arb (
    .clk(clk),
    .reset(reset),
    .req(pend),
    .grant(gnt),
    .idx(gidx),
    .valid(mvalid)
  );
  // an unmerged result blocks re-issue, which also enforces the two-cycle rest after core_life
  always_comb begin
    go = state == S_IDLE && start;
    elig = ~act & ~core_fault & ~pend;
    run_oh = elig & (~elig + 1'b1);
    issue = state == S_DISPATCH && issued < batch && |elig;
    mres = '0;
    for (int k = 0; k < NCORE; k++) if (gnt[k]) mres = pdat[k];
    nxt = state;
    unique case (state)
      S_IDLE:     nxt = go ? (batch_count == 32'd0 ? S_DONE : S_DISPATCH) : S_IDLE;
      S_DISPATCH: nxt = (issued == batch || &core_fault) ? S_DRAIN : S_DISPATCH;
      S_DRAIN:    nxt = (|act || |pend) ? S_DRAIN : S_DONE;
      default:    nxt = S_IDLE;
    endcase
  end
  assign busy = state == S_DISPATCH || state == S_DRAIN;
  assign done = state == S_DONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      core_run <= '0;
      act <= '0;
      pend <= '0;
      issued <= '0;
      batch <= '0;
      best_step <= '0;
      best_rng <= '0;
      best_core <= '0;
      jobs_done <= '0;
    end else begin
      state <= nxt;
      core_run <= issue ? run_oh : '0;
      act <= (act & ~core_life & ~wd_hit) | (issue ? run_oh : '0);
      pend <= go ? '0 : (pend & ~gnt) | (core_life & act);
      if (go) begin
        issued <= '0;
        batch <= batch_count;
        best_step <= '0;
        best_rng <= '0;
        best_core <= '0;
        jobs_done <= '0;
      end else begin
        if (issue) issued <= issued + 32'd1;
        if (mvalid) begin
          jobs_done <= jobs_done + 32'd1;
          if (mres.step > best_step) begin
            best_step <= mres.step;
            best_rng <= mres.rng;
            best_core <= gidx;
          end
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCORE; k++)
      if (core_life[k] && act[k]) pdat[k] <= core_data[k*RESW +: RESW];
  end
`ifdef SCHED_WATCHDOG_EN
  logic [31:0] wd [NCORE];
  always_comb begin
    wd_hit = '0;
    for (int k = 0; k < NCORE; k++) wd_hit[k] = act[k] && !core_life[k] && wd[k] == WDOG - 32'd1;
  end
  // a timed-out job stays counted as issued, so the batch can finish short
  always_ff @(posedge clk) begin
    if (reset) begin
      core_fault <= '0;
      for (int k = 0; k < NCORE; k++) wd[k] <= '0;
    end else begin
      for (int k = 0; k < NCORE; k++) begin
        wd[k] <= (issue && run_oh[k]) ? '0 : (act[k] ? wd[k] + 32'd1 : wd[k]);
        if (wd_hit[k]) core_fault[k] <= 1'b1;
      end
    end
  end
`else
  assign wd_hit = '0;
  assign core_fault = '0;
`endif
endmodule
